// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, main-control ALU_Op codes, RV32M funct3 codes and MDU FSM states.
package alu_ctrl_pkg;
  localparam int ALUOP_W  = 3;
  localparam int ALUCTL_W = 4;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_ctl_e;
  typedef enum logic [2:0] {
    OP_R   = 3'b000,
    OP_I   = 3'b001,
    OP_LUI = 3'b010,
    OP_BR  = 3'b011,
    OP_LS  = 3'b100
  } alu_op_e;
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_f3_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;
  // funct7[5] means SUB only for R-type, but SRA/SRAI for both R and I.
  function automatic logic [ALUCTL_W-1:0] alu_decode(input logic [ALUOP_W-1:0] op, input logic f7b5,
                                                     input logic [2:0] f3);
    logic [ALUCTL_W-1:0] r;
    case (f3)
      3'b000:  r = (op == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return (op == OP_R || op == OP_I) ? r : op == OP_LUI ? ALU_LUI : op == OP_BR ? ALU_SUB : ALU_ADD;
  endfunction
endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: shared hi/lo shift register with one adder for shift-add multiply and restoring divide.
module mdu_shift_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] m_init,
  input  logic [XLEN-1:0] lo_init,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN-1:0] hi, lo, m;
  logic [XLEN:0] sh;
  logic [XLEN+1:0] opa, opb, sum;
  logic ge;
  // Divide subtracts via the same adder (inverted operand, carry-in); two guard bits keep the borrow sign exact.
  always_comb begin
    sh = {hi, lo[XLEN-1]};
    opa = div_mode ? {1'b0, sh} : {2'b00, hi};
    opb = div_mode ? ~{2'b00, m} : lo[0] ? {2'b00, m} : '0;
    sum = opa + opb + {{(XLEN + 1){1'b0}}, div_mode};
    ge = !sum[XLEN+1];
    hi_nxt = div_mode ? (ge ? sum[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_nxt = div_mode ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= lo_init;
      m <= m_init;
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
endmodule

// File: rtl/alu_mdu_control.sv
// alu_mdu_control: ALU operation decode plus iterative RV32M sequencer that stalls the datapath.
// Divider hardware is built only when ALU_MDU_DIV_EN is defined; otherwise divide/remainder return 0.
module alu_mdu_control
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ALUOP_W-1:0]  ALU_Op_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  output logic [ALUCTL_W-1:0] ALU_Operation_o,
  output logic                mdu_sel_o,
  output logic                stall_o,
  output logic                done_o,
  output logic [XLEN-1:0]     mdu_result_o
);
  localparam int CW = $clog2(XLEN) + 1;
  state_e state, state_nxt;
  logic [CW-1:0] count;
  logic [1:0] f3_q;
  logic neg_q, is_m, start, run, last, special, div_mode, s1s, s2s, n1, n2;
  logic [XLEN-1:0] a1, a2, special_res, hi_nxt, lo_nxt, mul_res, fin_res;
  logic [2*XLEN-1:0] prod, sprod;
  assign is_m = ALU_Op_i == OP_R && funct7_i == 7'b0000001;
  assign start = state == S_IDLE && is_m;
  assign run = state == S_MUL || state == S_DIV;
  assign last = count == CW'(XLEN - 1);
  assign s1s = funct3_i[2] ? !funct3_i[0] : funct3_i != F3_MULHU;
  assign s2s = funct3_i[2] ? !funct3_i[0] : funct3_i == F3_MUL || funct3_i == F3_MULH;
  assign n1 = s1s && rs1_i[XLEN-1];
  assign n2 = s2s && rs2_i[XLEN-1];
  assign a1 = n1 ? -rs1_i : rs1_i;
  assign a2 = n2 ? -rs2_i : rs2_i;
  // Magnitudes go through the core; the sign is reapplied on the final iteration's output.
  assign prod = {hi_nxt, lo_nxt};
  assign sprod = neg_q ? -prod : prod;
  assign mul_res = f3_q == 2'b00 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
  logic rneg_q, div_zero, ovf;
  logic [XLEN-1:0] quo, rem;
  assign div_zero = rs2_i == '0;
  assign ovf = !funct3_i[0] && rs1_i == {1'b1, {(XLEN - 1){1'b0}}} && &rs2_i;
  assign special = funct3_i[2] && (div_zero || ovf);
  assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
  assign div_mode = state == S_DIV;
  assign quo = neg_q ? -lo_nxt : lo_nxt;
  assign rem = rneg_q ? -hi_nxt : hi_nxt;
  assign fin_res = div_mode ? (f3_q[1] ? rem : quo) : mul_res;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rneg_q <= 1'b0;
    else if (start) rneg_q <= n1;
`else
  assign special = funct3_i[2];
  assign special_res = '0;
  assign div_mode = 1'b0;
  assign fin_res = mul_res;
`endif
  mdu_shift_core #(.XLEN(XLEN)) u_core (
    .clk(clk),
    .reset(reset),
    .load(start),
    .step(run),
    .div_mode(div_mode),
    .m_init(funct3_i[2] ? a2 : a1),
    .lo_init(funct3_i[2] ? a1 : a2),
    .hi_nxt(hi_nxt),
    .lo_nxt(lo_nxt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= run && !last ? count + CW'(1) : '0;
    end
  always_comb begin
    state_nxt = state == S_IDLE ? (!is_m ? S_IDLE : special ? S_DONE : funct3_i[2] ? S_DIV : S_MUL)
              : run ? (last ? S_DONE : state) : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      f3_q <= '0;
      neg_q <= 1'b0;
      mdu_result_o <= '0;
    end else begin
      if (start) begin
        f3_q <= funct3_i[1:0];
        neg_q <= n1 ^ n2;
      end
      if (start && special) mdu_result_o <= special_res;
      else if (run && last) mdu_result_o <= fin_res;
    end
  // stall is gated by reset so a held M instruction cannot stall the pipe while in reset.
  always_comb begin
    ALU_Operation_o = alu_decode(ALU_Op_i, funct7_i[5], funct3_i);
    done_o = state == S_DONE;
    mdu_sel_o = state == S_DONE;
    stall_o = reset && (start || run);
  end
endmodule
